// File: rtl/product_accumulator.sv
// Frame accumulator: sums a run of unsigned 32-bit products into an ACC_W-bit result,
// then holds the result until the downstream stage accepts it.
module product_accumulator #(
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      prod,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [LEN_W-1:0] count;
    logic [ACC_W:0]   sum;

    // The extra top bit of sum is the carry-out that feeds the sticky overflow flag.
    always_comb begin
        sum = {1'b0, acc} + (ACC_W + 1)'(prod);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        overflow <= 1'b0;
                        if (len != '0) begin
                            count <= len;
                            state <= ACCUM;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                ACCUM: begin
                    if (prod_valid) begin
                        acc   <= sum[ACC_W-1:0];
                        count <= count - 1'b1;
                        if (sum[ACC_W]) begin
                            overflow <= 1'b1;
                        end
                        if (count == LEN_W'(1)) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (acc_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake flags decode straight from the state register, never from prod.
    assign prod_ready = (state == ACCUM);
    assign acc_valid  = (state == HOLD);
    assign busy       = (state != IDLE);
    assign acc_out    = acc;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a 40-bit and a 32-bit instance share all stimulus.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic [31:0] prod = '0;
    logic        prod_valid = 1'b0;
    logic        acc_ready = 1'b0;

    logic        prod_ready, acc_valid, overflow, busy;
    logic [39:0] acc_out;
    logic        prod_ready32, acc_valid32, overflow32, busy32;
    logic [31:0] acc_out32;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    product_accumulator #(.ACC_W(40), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .prod(prod),
        .prod_valid(prod_valid), .prod_ready(prod_ready), .acc_out(acc_out),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .overflow(overflow), .busy(busy)
    );

    product_accumulator #(.ACC_W(32), .LEN_W(8)) dut32 (
        .clk(clk), .rst(rst), .start(start), .len(len), .prod(prod),
        .prod_valid(prod_valid), .prod_ready(prod_ready32), .acc_out(acc_out32),
        .acc_valid(acc_valid32), .acc_ready(acc_ready), .overflow(overflow32), .busy(busy32)
    );

    typedef struct {
        logic        r;
        logic        s;
        logic [7:0]  l;
        logic [31:0] p;
        logic        pv;
        logic        ar;
        logic [39:0] e_acc;
        logic        e_valid;
        logic        e_ready;
        logic        e_busy;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic s, input logic [7:0] l,
                        input logic [31:0] p, input logic pv, input logic ar);
        rst = r; start = s; len = l; prod = p; prod_valid = pv; acc_ready = ar;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string nm, input logic [39:0] e_acc, input logic e_valid,
                           input logic e_ready, input logic e_busy, input logic e_ovf);
        chk({nm, ".acc_out"}, 64'(acc_out), 64'(e_acc));
        chk({nm, ".acc_valid"}, 64'(acc_valid), 64'(e_valid));
        chk({nm, ".prod_ready"}, 64'(prod_ready), 64'(e_ready));
        chk({nm, ".busy"}, 64'(busy), 64'(e_busy));
        chk({nm, ".overflow"}, 64'(overflow), 64'(e_ovf));
    endtask

    initial begin
        // Basic frame of four 0xFFFE0001 products, HOLD backpressure, release,
        // empty frame, and a stray prod_valid while IDLE.
        vecs[0]  = '{1'b0, 1'b1, 8'd4, 32'h0,        1'b0, 1'b0, 40'h0,          1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 8'd0, 32'hFFFE0001, 1'b1, 1'b0, 40'h00FFFE0001, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 8'd0, 32'hFFFE0001, 1'b1, 1'b0, 40'h01FFFC0002, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'd0, 32'hFFFE0001, 1'b1, 1'b0, 40'h02FFFA0003, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 8'd0, 32'hFFFE0001, 1'b1, 1'b0, 40'h03FFF80004, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 8'd0, 32'h0,        1'b0, 1'b0, 40'h03FFF80004, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 8'd0, 32'h0,        1'b0, 1'b1, 40'h03FFF80004, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'd0, 32'h0,        1'b0, 1'b0, 40'h0,          1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 8'd0, 32'h0,        1'b0, 1'b0, 40'h0,          1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 8'd0, 32'h0,        1'b0, 1'b1, 40'h0,          1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 8'd0, 32'h1234,     1'b1, 1'b0, 40'h0,          1'b0, 1'b0, 1'b0, 1'b0};

        step(1'b1, 1'b0, 8'd0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'd3, 32'h5, 1'b1, 1'b1);
        chk_all("reset", 40'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].r, vecs[i].s, vecs[i].l, vecs[i].p, vecs[i].pv, vecs[i].ar);
            chk_all($sformatf("vec%0d", i), vecs[i].e_acc, vecs[i].e_valid,
                    vecs[i].e_ready, vecs[i].e_busy, vecs[i].e_ovf);
        end

        // Bubbles between products 5, 7, 9, then 5 cycles of backpressure in HOLD.
        step(1'b0, 1'b1, 8'd3, 32'h0, 1'b0, 1'b0);
        begin
            logic [31:0] pv_list[3];
            logic [39:0] run;
            pv_list = '{32'd5, 32'd7, 32'd9};
            run = '0;
            for (int k = 0; k < 3; k++) begin
                step(1'b0, 1'b0, 8'd0, 32'hDEAD, 1'b0, 1'b0);
                step(1'b0, 1'b0, 8'd0, 32'hBEEF, 1'b0, 1'b0);
                chk($sformatf("bubble%0d.acc_out", k), 64'(acc_out), 64'(run));
                step(1'b0, 1'b0, 8'd0, pv_list[k], 1'b1, 1'b0);
                run = run + 40'(pv_list[k]);
            end
        end
        chk_all("bubble.done", 40'd21, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 8'd0, 32'h0, 1'b0, 1'b0);
            chk($sformatf("hold%0d.acc_out", k), 64'(acc_out), 64'd21);
            chk($sformatf("hold%0d.acc_valid", k), 64'(acc_valid), 64'd1);
        end
        step(1'b0, 1'b0, 8'd0, 32'h0, 1'b0, 1'b1);
        chk_all("bubble.release", 40'd21, 1'b0, 1'b0, 1'b0, 1'b0);

        // Start pulses inside ACCUM and HOLD must be ignored.
        step(1'b0, 1'b1, 8'd2, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'd0, 32'd3, 1'b1, 1'b0);
        step(1'b0, 1'b1, 8'd5, 32'd4, 1'b1, 1'b0);
        chk_all("ignstart.hold", 40'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 8'd0, 32'h0, 1'b0, 1'b0);
        chk_all("ignstart.hold2", 40'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'd0, 32'h0, 1'b0, 1'b1);

        // Carry out of bit 31 on the narrow instance; the wide one just grows.
        step(1'b0, 1'b1, 8'd2, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'd0, 32'hFFFE0001, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'd0, 32'h00020000, 1'b1, 1'b0);
        chk("ovf32.acc_out", 64'(acc_out32), 64'h1);
        chk("ovf32.overflow", 64'(overflow32), 64'd1);
        chk("ovf32.acc_valid", 64'(acc_valid32), 64'd1);
        chk_all("ovf40", 40'h0100000001, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'd0, 32'h0, 1'b0, 1'b0);
        chk("ovf32.sticky", 64'(overflow32), 64'd1);
        step(1'b0, 1'b0, 8'd0, 32'h0, 1'b0, 1'b1);
        chk("ovf32.idle_keep", 64'(overflow32), 64'd1);
        step(1'b0, 1'b1, 8'd1, 32'h0, 1'b0, 1'b0);
        chk("ovf32.cleared", 64'(overflow32), 64'd0);
        chk("ovf32.acc_cleared", 64'(acc_out32), 64'd0);
        step(1'b0, 1'b0, 8'd0, 32'd1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'd0, 32'h0, 1'b0, 1'b1);

        // Reset after two accepts, then a frame starting the first cycle after reset.
        step(1'b0, 1'b1, 8'd4, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'd0, 32'h11111111, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'd0, 32'h22222222, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'd0, 32'h33333333, 1'b1, 1'b0);
        chk_all("midrst", 40'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'd1, 32'h0, 1'b0, 1'b0);
        chk_all("postrst.start", 40'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'd0, 32'h12345678, 1'b1, 1'b0);
        chk_all("postrst.done", 40'h0012345678, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'd0, 32'h0, 1'b0, 1'b1);

        // Maximum-length frame.
        step(1'b0, 1'b1, 8'd255, 32'h0, 1'b0, 1'b0);
        for (int k = 0; k < 254; k++) begin
            step(1'b0, 1'b0, 8'd0, 32'hFFFE0001, 1'b1, 1'b0);
        end
        chk("maxlen.still_accum", 64'(prod_ready), 64'd1);
        step(1'b0, 1'b0, 8'd0, 32'hFFFE0001, 1'b1, 1'b0);
        begin
            int waited;
            waited = 0;
            while (!acc_valid && waited < 8) begin
                step(1'b0, 1'b0, 8'd0, 32'h0, 1'b0, 1'b0);
                waited++;
            end
            chk("maxlen.latency", 64'(waited), 64'd0);
        end
        chk_all("maxlen", 40'hFEFE0200FF, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'd0, 32'h0, 1'b0, 1'b0);
        chk_all("hold_rst", 40'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL provide parameter ACC_W, default 40, the accumulator width in bits; legal range 32 to 64.
REQ-002 SHALL provide parameter LEN_W, default 8, the frame-length field width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: begins a frame; sampled only in IDLE.
REQ-006 SHALL have port len, input, LEN_W bits: the number of products in the frame; sampled with start.
REQ-007 SHALL have port prod, input, 32 bits: an unsigned product word from the upstream 16x16 multiplier.
REQ-008 SHALL have port prod_valid, input, 1 bit: prod is valid.
REQ-009 SHALL have port prod_ready, output, 1 bit: the block accepts prod this cycle.
REQ-010 SHALL have port acc_out, output, ACC_W bits: the accumulated frame result.
REQ-011 SHALL have port acc_valid, output, 1 bit: acc_out holds a completed frame result.
REQ-012 SHALL have port acc_ready, input, 1 bit: the downstream stage consumes acc_out.
REQ-013 SHALL have port overflow, output, 1 bit: a sticky flag for carry-out of the accumulator in the current or last frame.
REQ-014 SHALL have port busy, output, 1 bit: high in every state other than IDLE.

Function
REQ-015 SHALL implement an FSM with exactly three states: IDLE, ACCUM and HOLD.
REQ-016 In IDLE with start=1 and len!=0: next cycle, acc=0, overflow=0, count=len, state=ACCUM.
REQ-017 In IDLE with start=1 and len==0: next cycle, acc=0, overflow=0, state=HOLD (empty frame yields a 0 result).
REQ-018 SHALL ignore start while in ACCUM or HOLD, with no state change and no error.
REQ-019 In ACCUM, SHALL drive prod_ready=1; in IDLE and HOLD, SHALL drive prod_ready=0; prod_ready SHALL be driven directly from state.
REQ-020 A product is accepted only on a cycle with prod_valid=1 and prod_ready=1; prod_valid=0 cycles (bubbles) SHALL leave acc and count unchanged.
REQ-021 On acceptance, SHALL update acc to (acc + zero-extended prod) mod 2^ACC_W and decrement count by 1.
REQ-022 SHALL set overflow to 1 on any acceptance whose sum carries out of bit ACC_W-1; overflow then stays 1 until the next frame start or reset.
REQ-023 When the accepted product makes count reach 0, SHALL enter HOLD next cycle, with acc_out equal to the final sum and acc_valid=1 on that same cycle; latency is 1 cycle from the last accept.
REQ-024 In HOLD, SHALL keep acc_out and overflow stable while acc_valid=1 and acc_ready=0, for any number of cycles.
REQ-025 In HOLD with acc_ready=1, SHALL enter IDLE next cycle with acc_valid=0.
REQ-026 acc_out SHALL retain the last result in IDLE until the next frame start clears it.
REQ-027 acc_valid SHALL be 1 only in HOLD; busy SHALL equal (state != IDLE).
REQ-028 acc_out SHALL be a direct register output, with no combinational path from prod to acc_out or acc_valid.

Reset
REQ-029 On rst=1 at a clock edge, SHALL force state=IDLE, acc_out=0, count=0, overflow=0, acc_valid=0, prod_ready=0 and busy=0.
REQ-030 rst SHALL take priority over all other inputs, including mid-frame in ACCUM and in HOLD; a partial sum SHALL be discarded and never presented.
REQ-031 The first start SHALL be honoured on the first cycle after rst deasserts.

Verification
REQ-032 Basic frame: start with len=4, then 4 consecutive products of 0xFFFE0001 -> acc_valid rises 1 cycle after the 4th accept, acc_out=0x03FFF80004, overflow=0.
REQ-033 Bubbles and backpressure: len=3 with products 5, 7, 9 and prod_valid gapped 2 cycles between each; acc_ready held 0 for 5 cycles in HOLD -> acc_out=21 stays stable, then drops to IDLE 1 cycle after acc_ready=1.
REQ-034 Overflow (ACC_W=32): len=2 with products 0xFFFE0001 and 0x00020000 -> acc_out=0x00000001, overflow=1; the next start clears overflow to 0.
REQ-035 Empty frame and ignored start: start with len=0 -> HOLD with acc_out=0 on the next cycle; a start pulse during ACCUM of a len=2 frame is ignored and the frame result is unaffected.
REQ-036 Reset mid-frame: len=4, rst after 2 accepts -> all outputs 0 and state IDLE next cycle; a new len=1 frame with product 0x12345678 -> acc_out=0x0012345678.
REQ-037 Maximum length: len=255 with all products 0xFFFE0001 -> acc_out=0xFEFE0200FF, overflow=0.
